// File: rtl/nmea_sentence_tx.sv
`default_nettype none
// -----------------------------------------------------------------------------
// nmea_sentence_tx: emits "$" + HEADER + payload + "*hh" + CRLF, XOR checksum on the fly. Rev 1.0
// -----------------------------------------------------------------------------
module nmea_sentence_tx #(
  parameter int                      HEADER_LEN  = 6,
  parameter logic [8*HEADER_LEN-1:0] HEADER      = "GPZDA,",
  parameter int                      MAX_PAYLOAD = 74
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  localparam int              HW      = $clog2(HEADER_LEN + 1);
  localparam int              PW      = $clog2(MAX_PAYLOAD + 1);
  localparam logic [HW-1:0]   C_HLAST = HW'(HEADER_LEN - 1);
  localparam logic [PW-1:0]   C_PMAX  = PW'(MAX_PAYLOAD);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_PAY, S_STAR, S_CSH, S_CSL, S_CR, S_LF, S_WAIT
  } state_t;

  state_t        state_q;
  logic [HW-1:0] hidx_q;
  logic [PW-1:0] pcnt_q;
  logic [7:0]    csum_q;
  logic [7:0]    dout_q;
  logic          dout_valid_q;
  logic          overflow_q;

  logic          w_adv;
  logic          w_take;
  logic [7:0]    w_hdr_char;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Constant-index mux keeps the header lookup free of out-of-range selects.
  always_comb begin
    w_hdr_char = 8'h00;
    for (int k = 0; k < HEADER_LEN; k++) begin
      if (hidx_q == HW'(k)) w_hdr_char = HEADER[8*(HEADER_LEN-1-k) +: 8];
    end
  end

  assign w_adv      = !dout_valid_q || dout_ready;
  assign din_ready  = (state_q == S_PAY) && w_adv && (pcnt_q < C_PMAX);
  assign w_take     = din_valid && din_ready;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_WAIT) && dout_valid_q && dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hidx_q       <= '0;
      pcnt_q       <= '0;
      csum_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dout_valid_q <= start;
          if (start) begin
            csum_q     <= '0;
            hidx_q     <= '0;
            pcnt_q     <= '0;
            overflow_q <= 1'b0;
            dout_q     <= 8'h24;
            state_q    <= S_HDR;
          end
        end
        S_HDR: if (w_adv) begin
          dout_q       <= w_hdr_char;
          dout_valid_q <= 1'b1;
          csum_q       <= csum_q ^ w_hdr_char;
          hidx_q       <= hidx_q + HW'(1);
          if (hidx_q == C_HLAST) state_q <= S_PAY;
        end
        S_PAY: begin
          if (w_take) begin
            dout_q       <= din;
            dout_valid_q <= 1'b1;
            csum_q       <= csum_q ^ din;
            pcnt_q       <= pcnt_q + PW'(1);
            if (din_last) begin
              state_q <= S_STAR;
            end else if (pcnt_q == C_PMAX - PW'(1)) begin
              // Payload cut short: later upstream bytes stay pending.
              overflow_q <= 1'b1;
              state_q    <= S_STAR;
            end
          end else if (dout_ready) begin
            dout_valid_q <= 1'b0;
          end
        end
        S_STAR: if (w_adv) begin
          dout_q       <= 8'h2A;
          dout_valid_q <= 1'b1;
          state_q      <= S_CSH;
        end
        S_CSH: if (w_adv) begin
          dout_q       <= hex_char(csum_q[7:4]);
          dout_valid_q <= 1'b1;
          state_q      <= S_CSL;
        end
        S_CSL: if (w_adv) begin
          dout_q       <= hex_char(csum_q[3:0]);
          dout_valid_q <= 1'b1;
          state_q      <= S_CR;
        end
        S_CR: if (w_adv) begin
          dout_q       <= 8'h0D;
          dout_valid_q <= 1'b1;
          state_q      <= S_LF;
        end
        S_LF: if (w_adv) begin
          dout_q       <= 8'h0A;
          dout_valid_q <= 1'b1;
          state_q      <= S_WAIT;
        end
        S_WAIT: if (dout_ready) begin
          dout_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nmea_sentence_tx.sv
`default_nettype none
// Bench for nmea_sentence_tx: default config (inst 0) and MAX_PAYLOAD=4 (inst 1),
// random payloads checked against a string-level sentence model.
module tb_nmea_sentence_tx;

  typedef logic [7:0] bq_t[$];
  localparam int BIG_MAX   = 74;
  localparam int SMALL_MAX = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      start, din_valid, din_last, din_ready, dout_valid, dout_ready;
  logic [1:0]      busy, done, overflow;
  logic [1:0][7:0] din, dout;

  int   total = 0;
  int   bad   = 0;
  int   done_cnt [2];
  bq_t  got0, got1;

  logic [1:0]      pv   = '0;
  logic [1:0]      pr   = '0;
  logic [1:0][7:0] pd   = '0;
  logic            prst = 1'b1;

  always #5 clk = ~clk;

  nmea_sentence_tx u_big (
    .clk(clk), .rst(rst), .start(start[0]), .din(din[0]), .din_valid(din_valid[0]),
    .din_last(din_last[0]), .din_ready(din_ready[0]), .dout(dout[0]),
    .dout_valid(dout_valid[0]), .dout_ready(dout_ready[0]), .busy(busy[0]),
    .done(done[0]), .overflow(overflow[0])
  );

  nmea_sentence_tx #(.MAX_PAYLOAD(SMALL_MAX)) u_small (
    .clk(clk), .rst(rst), .start(start[1]), .din(din[1]), .din_valid(din_valid[1]),
    .din_last(din_last[1]), .din_ready(din_ready[1]), .dout(dout[1]),
    .dout_valid(dout_valid[1]), .dout_ready(dout_ready[1]), .busy(busy[1]),
    .done(done[1]), .overflow(overflow[1])
  );

  // Output-side monitor: hold rule, done qualification, character capture.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!prst && pv[i] && !pr[i]) begin
        total++;
        assert (dout_valid[i] === 1'b1 && dout[i] === pd[i])
          else begin bad++; $error("FAIL hold%0d: got v=%b d=%h exp v=1 d=%h", i, dout_valid[i], dout[i], pd[i]); end
      end
      if (done[i]) begin
        done_cnt[i]++;
        total++;
        assert ({dout_valid[i], dout_ready[i], dout[i]} === {2'b11, 8'h0A})
          else begin bad++; $error("FAIL done_lf%0d: got v=%b r=%b d=%h exp 1 1 0a", i, dout_valid[i], dout_ready[i], dout[i]); end
      end
      if (dout_valid[i] && dout_ready[i]) begin
        if (i == 0) got0.push_back(dout[i]);
        else        got1.push_back(dout[i]);
      end
    end
    pv   <= dout_valid;
    pr   <= dout_ready;
    pd   <= dout;
    prst <= rst;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish exp finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] hx(input logic [3:0] n);
    string hs = "0123456789ABCDEF";
    return 8'(hs[int'(n)]);
  endfunction

  // Whole sentence from the textual rules: "$" header payload "*" hh CR LF.
  function automatic bq_t model(input bq_t pay, input bit last, input int maxp);
    bq_t        s;
    logic [7:0] x = 8'h00;
    string      h = "GPZDA,";
    int         n;
    n = (last && pay.size() <= maxp) ? pay.size() : maxp;
    s.push_back(8'h24);
    for (int k = 0; k < h.len(); k++) begin s.push_back(8'(h[k])); x ^= 8'(h[k]); end
    for (int k = 0; k < n; k++) begin s.push_back(pay[k]); x ^= pay[k]; end
    s.push_back(8'h2A);
    s.push_back(hx(x[7:4]));
    s.push_back(hx(x[3:0]));
    s.push_back(8'h0D);
    s.push_back(8'h0A);
    return s;
  endfunction

  function automatic bq_t rand_pay(input int n);
    bq_t p;
    for (int k = 0; k < n; k++) p.push_back(8'($urandom_range(33, 126)));
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] g, input logic [31:0] e);
    total++;
    assert (g === e) else begin bad++; $error("FAIL %s: got %0h exp %0h", tag, g, e); end
  endtask

  task automatic check_seq(input string tag, input bq_t g, input bq_t e);
    total++;
    assert (g.size() === e.size())
      else begin bad++; $error("FAIL %s_len: got %0d exp %0d", tag, g.size(), e.size()); end
    for (int k = 0; k < e.size() && k < g.size(); k++) begin
      total++;
      assert (g[k] === e[k])
        else begin bad++; $error("FAIL %s[%0d]: got %h exp %h", tag, k, g[k], e[k]); end
    end
  endtask

  // Drives one sentence; mode 0 = full rate, mode 1 = ready 1010.. and random din gaps.
  task automatic run(input int sel, input bq_t pay, input bit last, input int mode,
                     input int restart_at, input bit rst_at_star,
                     output int cycles, output int taken);
    int idx = 0;
    int cyc = 0;
    bit fin = 1'b0;
    bit acc;
    cycles = -1;
    if (sel == 0) got0.delete(); else got1.delete();
    done_cnt[sel] = 0;
    start[sel] = 1'b1;
    while (!fin && cyc < 2000) begin
      din_valid[sel]  = (idx < pay.size()) && (mode == 0 || $urandom_range(0, 2) != 0);
      din[sel]        = (idx < pay.size()) ? pay[idx] : 8'h00;
      din_last[sel]   = last && (idx == pay.size() - 1);
      dout_ready[sel] = (mode == 0) || (cyc[0] == 1'b0);
      if (cyc == restart_at) start[sel] = 1'b1;
      @(negedge clk);
      acc = din_valid[sel] && din_ready[sel];
      if (done[sel]) begin fin = 1'b1; cycles = cyc; end
      @(posedge clk); #1;
      start[sel] = 1'b0;
      if (acc) idx++;
      cyc++;
      if (rst_at_star && dout_valid[sel] && dout[sel] == 8'h2A) begin rst = 1'b1; fin = 1'b1; end
    end
    total++;
    assert (fin) else begin bad++; $error("FAIL timeout%0d: got cyc=%0d exp done", sel, cyc); end
    din_valid[sel]  = 1'b0;
    din_last[sel]   = 1'b0;
    dout_ready[sel] = 1'b1;
    taken = idx;
  endtask

  initial begin
    bq_t p, e;
    int  cyc, tk, n;
    start = '0; din_valid = '0; din_last = '0; din = '0; dout_ready = '0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    din_valid = 2'b11;
    @(negedge clk);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_din_ready", 32'(din_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    @(posedge clk); #1;
    din_valid = '0;

    // Basic single-byte sentence at full rate.
    p = '{8'h31};
    run(0, p, 1'b1, 0, -1, 1'b0, cyc, tk);
    check_seq("basic", got0, model(p, 1'b1, BIG_MAX));
    chk("basic_cycles", cyc, 13);
    chk("basic_done_cnt", done_cnt[0], 1);
    chk("basic_ovf", overflow[0], 0);
    chk("basic_idle_busy", busy[0], 0);

    // Same sentence under backpressure, then random payloads.
    run(0, p, 1'b1, 1, -1, 1'b0, cyc, tk);
    check_seq("bp", got0, model(p, 1'b1, BIG_MAX));
    chk("bp_done_cnt", done_cnt[0], 1);
    for (int r = 0; r < 4; r++) begin
      p = rand_pay($urandom_range(1, 12));
      run(0, p, 1'b1, 1, -1, 1'b0, cyc, tk);
      check_seq("rand", got0, model(p, 1'b1, BIG_MAX));
      chk("rand_ovf", overflow[0], 0);
    end

    // Truncation at MAX_PAYLOAD=4: "5" must remain pending.
    p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    run(1, p, 1'b0, 0, -1, 1'b0, cyc, tk);
    e = model(p, 1'b0, SMALL_MAX);
    check_seq("trunc", got1, e);
    chk("trunc_ovf", overflow[1], 1);
    chk("trunc_taken", tk, SMALL_MAX);
    din_valid[1] = 1'b1;
    din[1] = 8'h35;
    @(negedge clk);
    chk("trunc_pending_ready", din_ready[1], 0);
    @(posedge clk); #1;
    din_valid[1] = 1'b0;
    chk("trunc_ovf_sticky", overflow[1], 1);

    // Exact fit: last on the 4th byte gives the same text, no overflow.
    p = '{8'h31, 8'h32, 8'h33, 8'h34};
    run(1, p, 1'b1, 0, -1, 1'b0, cyc, tk);
    check_seq("fit", got1, e);
    chk("fit_ovf", overflow[1], 0);

    // Random over-length payload on the small instance, with backpressure.
    p = rand_pay($urandom_range(5, 8));
    run(1, p, 1'b1, 1, -1, 1'b0, cyc, tk);
    check_seq("rtrunc", got1, model(p, 1'b1, SMALL_MAX));
    chk("rtrunc_ovf", overflow[1], 1);

    // Default-size boundary: 75 bytes truncated, 74 bytes with last fits.
    p = rand_pay(BIG_MAX + 1);
    run(0, p, 1'b0, 1, -1, 1'b0, cyc, tk);
    check_seq("bigtrunc", got0, model(p, 1'b0, BIG_MAX));
    chk("bigtrunc_ovf", overflow[0], 1);
    p = rand_pay(BIG_MAX);
    run(0, p, 1'b1, 0, -1, 1'b0, cyc, tk);
    check_seq("bigfit", got0, model(p, 1'b1, BIG_MAX));
    chk("bigfit_ovf", overflow[0], 0);

    // Start while busy (mid-payload), then start coinciding with done.
    p = rand_pay(5);
    run(0, p, 1'b1, 1, 10, 1'b0, cyc, tk);
    e = model(p, 1'b1, BIG_MAX);
    repeat (5) @(posedge clk);
    #1;
    check_seq("busy_start", got0, e);
    chk("busy_start_done_cnt", done_cnt[0], 1);
    chk("busy_start_busy", busy[0], 0);
    p = '{8'h31};
    run(0, p, 1'b1, 0, 13, 1'b0, cyc, tk);
    e = model(p, 1'b1, BIG_MAX);
    repeat (5) @(posedge clk);
    #1;
    check_seq("done_start", got0, e);
    chk("done_start_done_cnt", done_cnt[0], 1);
    chk("done_start_busy", busy[0], 0);

    // Reset while the checksum high digit is pending, then a clean sentence.
    n = $urandom_range(1, 4);
    p = rand_pay(n);
    run(0, p, 1'b1, 0, -1, 1'b1, cyc, tk);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_valid", dout_valid[0], 0);
    chk("rst_mid_busy", busy[0], 0);
    chk("rst_mid_done_cnt", done_cnt[0], 0);
    p = rand_pay($urandom_range(1, 6));
    run(0, p, 1'b1, 1, -1, 1'b0, cyc, tk);
    check_seq("after_rst", got0, model(p, 1'b1, BIG_MAX));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
